dma_arbiter_rr: RTL and testbench

Parametrised channel arbiter for the DMA engine. It selects one of NCH channels at a time and holds the shared transfer datapath enabled until that channel reports completion. The block sits between the per-channel request, config and FIFO status logic and the single transfer engine. It adds three things to the fixed 4-channel scheme: a configurable channel count, selectable fixed or round-robin priority, and a per-grant watchdog.

---
 rtl/dma_arbiter_rr.sv | 154 +++++++++++++++
 tb/tb_dma_arbiter_rr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter_rr.sv
// DMA channel arbiter: three-tier eligibility, fixed or round-robin winner selection,
// and a per-grant watchdog that holds the transfer datapath on one channel at a time.
module dma_arbiter_rr #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned RR_MODE = 1,
   parameter int unsigned TIMEOUT = 0,
   parameter int unsigned CW      = 16,
   localparam int unsigned IW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   input  logic [NCH-1:0] req_i,
   input  logic [NCH-1:0] ch_en_i,
   input  logic [NCH-1:0] target_i,
   input  logic [NCH-1:0] t0_done_i,
   input  logic [NCH-1:0] fifo_empty_i,
   input  logic           req_done_i,
   output logic [NCH-1:0] en_o,
   output logic [NCH-1:0] ack_o,
   output logic [IW-1:0]  grant_id_o,
   output logic           busy_o,
   output logic           timeout_o
);

   typedef enum logic [1:0] {StIdle, StStart, StWork} state_e;

   state_e         cs_q, ns;
   logic [NCH-1:0] en_q, en_d;
   logic [NCH-1:0] ack_q, ack_d;
   logic [IW-1:0]  grant_q, grant_d;
   logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           to_q, to_d;

   logic [NCH-1:0] t1, t2, t3, tier;
   logic [IW-1:0]  win;
   logic           any_elig;

   // ack_q masks a channel's still-asserted request in the cycle it is acknowledged
   assign t1 = req_i & ~ack_q;
   assign t2 = ch_en_i & ~target_i & ~t0_done_i;
   assign t3 = ch_en_i & target_i & ~fifo_empty_i;

   always_comb begin
      tier = t3;
      if (t1 != '0) begin
         tier = t1;
      end else if (t2 != '0) begin
         tier = t2;
      end
   end

   assign any_elig = |tier;

   always_comb begin
      int   idx;
      logic found;
      win   = '0;
      idx   = 0;
      found = 1'b0;
      if (RR_MODE == 0) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (tier[i]) begin
               win = IW'(i);
            end
         end
      end else begin
         // Search starts just after the last winner, so it becomes lowest priority
         for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NCH;
            if (!found && tier[idx[IW-1:0]]) begin
               win   = idx[IW-1:0];
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ns       = cs_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      ack_d    = '0;
      to_d     = 1'b0;
      unique case (cs_q)
         StIdle: begin
            if (any_elig) begin
               ns       = StStart;
               grant_d  = win;
               rr_ptr_d = win;
            end
         end
         StStart: begin
            ns    = StWork;
            cnt_d = '0;
         end
         StWork: begin
            if (req_done_i) begin
               if (req_i[grant_q]) begin
                  ack_d[grant_q] = 1'b1;
               end
               if (any_elig) begin
                  ns       = StStart;
                  grant_d  = win;
                  rr_ptr_d = win;
               end else begin
                  ns = StIdle;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
               to_d = 1'b1;
               ns   = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ns = StIdle;
      endcase
   end

   always_comb begin
      en_d = '0;
      if (ns == StWork) begin
         en_d = NCH'(1) << grant_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cs_q     <= StIdle;
         en_q     <= '0;
         ack_q    <= '0;
         grant_q  <= '0;
         rr_ptr_q <= IW'(NCH - 1);
         cnt_q    <= '0;
         to_q     <= 1'b0;
      end else begin
         cs_q     <= ns;
         en_q     <= en_d;
         ack_q    <= ack_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
      end
   end

   assign en_o       = en_q;
   assign ack_o      = ack_q;
   assign grant_id_o = grant_q;
   assign busy_o     = (cs_q != StIdle);
   assign timeout_o  = to_q;

endmodule

// File: tb/tb_dma_arbiter_rr.sv
// Directed bench for dma_arbiter_rr: a fixed-priority instance and a round-robin instance
// with an 8-cycle watchdog share one set of inputs; each sequence checks one of them.
module tb_dma_arbiter_rr;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] req = '0, ch_en = '0, target = '0, t0_done = '0, fifo_empty = '0;
   logic       req_done = 1'b0;

   logic [3:0] en_f, ack_f, en_r, ack_r;
   logic [1:0] gid_f, gid_r;
   logic       busy_f, to_f, busy_r, to_r;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dma_arbiter_rr #(.NCH(4), .RR_MODE(0), .TIMEOUT(0), .CW(16)) u_fixed (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .ch_en_i(ch_en), .target_i(target),
      .t0_done_i(t0_done), .fifo_empty_i(fifo_empty), .req_done_i(req_done),
      .en_o(en_f), .ack_o(ack_f), .grant_id_o(gid_f), .busy_o(busy_f), .timeout_o(to_f)
   );

   dma_arbiter_rr #(.NCH(4), .RR_MODE(1), .TIMEOUT(8), .CW(4)) u_rr (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .ch_en_i(ch_en), .target_i(target),
      .t0_done_i(t0_done), .fifo_empty_i(fifo_empty), .req_done_i(req_done),
      .en_o(en_r), .ack_o(ack_r), .grant_id_o(gid_r), .busy_o(busy_r), .timeout_o(to_r)
   );

   typedef struct packed {
      logic       sel;   // 0 = fixed instance, 1 = round-robin instance
      logic       rst;
      logic [3:0] req;
      logic       done;
      logic [3:0] en;
      logic [3:0] ack;
      logic [1:0] gid;
      logic       busy;
   } vec_t;

   vec_t tbl [0:19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic sel, input logic d, input logic [3:0] e_en,
                       input logic [3:0] e_ack, input logic [1:0] e_gid, input logic e_busy,
                       input logic e_to, input string tag);
      req_done = d;
      @(posedge clk);
      #1;
      chk({tag, ".en"},      sel ? en_r   : en_f,   e_en);
      chk({tag, ".ack"},     sel ? ack_r  : ack_f,  e_ack);
      chk({tag, ".gid"},     sel ? gid_r  : gid_f,  e_gid);
      chk({tag, ".busy"},    sel ? busy_r : busy_f, e_busy);
      chk({tag, ".timeout"}, sel ? to_r   : to_f,   e_to);
   endtask

   task automatic do_reset();
      rstn       = 1'b0;
      req        = '0;
      ch_en      = '0;
      target     = '0;
      t0_done    = '0;
      fifo_empty = '0;
      req_done   = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Fixed priority, req=1010 held: channel 1 wins every time
      tbl[0]  = '{1'b0, 1'b1, 4'b1010, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0000, 4'b0010, 2'd1, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0000, 4'b0010, 2'd1, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 4'b1010, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
      // Round robin, req=1111 held: 0,1,2,3,0 back to back
      tbl[9]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0001, 2'd1, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0010, 2'd2, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0100, 2'd3, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b1};
      tbl[17] = '{1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'b1000, 2'd0, 1'b1};
      tbl[18] = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1};
      tbl[19] = '{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};

      do_reset();
      #1;
      chk("rst.en_f",   en_f,   4'b0000);
      chk("rst.ack_f",  ack_f,  4'b0000);
      chk("rst.gid_f",  gid_f,  2'd0);
      chk("rst.busy_f", busy_f, 1'b0);
      chk("rst.to_f",   to_f,   1'b0);
      chk("rst.en_r",   en_r,   4'b0000);
      chk("rst.busy_r", busy_r, 1'b0);
      chk("rst.to_r",   to_r,   1'b0);

      for (int i = 0; i < 20; i++) begin
         if (tbl[i].rst) do_reset();
         req = tbl[i].req;
         step(tbl[i].sel, tbl[i].done, tbl[i].en, tbl[i].ack, tbl[i].gid, tbl[i].busy, 1'b0,
              $sformatf("vec%0d", i));
      end

      // Tier ordering: ch2 is T1, ch1/ch3 T2, ch0 T3
      do_reset();
      ch_en      = 4'b1111;
      target     = 4'b0001;
      fifo_empty = 4'b1110;
      req        = 4'b0100;
      step(1, 0, 4'b0000, 4'b0000, 2'd2, 1, 0, "tier.start2");
      step(1, 0, 4'b0100, 4'b0000, 2'd2, 1, 0, "tier.work2");
      // req still high at completion: acked, and still T1 so granted again
      step(1, 1, 4'b0000, 4'b0100, 2'd2, 1, 0, "tier.ack2");
      req     = 4'b0000;
      t0_done = 4'b0100;
      step(1, 0, 4'b0100, 4'b0000, 2'd2, 1, 0, "tier.work2b");
      step(1, 1, 4'b0000, 4'b0000, 2'd3, 1, 0, "tier.start3");
      t0_done = 4'b1100;
      step(1, 0, 4'b1000, 4'b0000, 2'd3, 1, 0, "tier.work3");
      step(1, 1, 4'b0000, 4'b0000, 2'd1, 1, 0, "tier.start1");
      t0_done = 4'b1110;
      step(1, 0, 4'b0010, 4'b0000, 2'd1, 1, 0, "tier.work1");
      step(1, 1, 4'b0000, 4'b0000, 2'd0, 1, 0, "tier.start0");
      fifo_empty = 4'b1111;
      step(1, 0, 4'b0001, 4'b0000, 2'd0, 1, 0, "tier.work0");
      step(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, "tier.idle");

      // Watchdog expiry after 8 WORK cycles, then channel 1 granted
      do_reset();
      req = 4'b0011;
      step(1, 0, 4'b0000, 4'b0000, 2'd0, 1, 0, "wd.start0");
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 4'b0001, 4'b0000, 2'd0, 1, 0, $sformatf("wd.work%0d", i));
      end
      step(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 1, "wd.expire");
      step(1, 0, 4'b0000, 4'b0000, 2'd1, 1, 0, "wd.start1");
      step(1, 0, 4'b0010, 4'b0000, 2'd1, 1, 0, "wd.work1");
      req = 4'b0000;
      step(1, 1, 4'b0000, 4'b0000, 2'd1, 0, 0, "wd.idle");

      // req_done on the expiry cycle wins: ack, no timeout
      do_reset();
      req = 4'b0001;
      step(1, 0, 4'b0000, 4'b0000, 2'd0, 1, 0, "race.start");
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 4'b0001, 4'b0000, 2'd0, 1, 0, $sformatf("race.work%0d", i));
      end
      step(1, 1, 4'b0000, 4'b0001, 2'd0, 1, 0, "race.done");
      req = 4'b0000;
      step(1, 0, 4'b0001, 4'b0000, 2'd0, 1, 0, "race.work");
      step(1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, "race.idle");

      // Asynchronous reset mid-WORK
      do_reset();
      req = 4'b0100;
      step(1, 0, 4'b0000, 4'b0000, 2'd2, 1, 0, "arst.start");
      step(1, 0, 4'b0100, 4'b0000, 2'd2, 1, 0, "arst.work");
      #2;
      rstn = 1'b0;
      #1;
      chk("arst.en",   en_r,   4'b0000);
      chk("arst.ack",  ack_r,  4'b0000);
      chk("arst.busy", busy_r, 1'b0);
      chk("arst.gid",  gid_r,  2'd0);
      @(negedge clk);
      rstn = 1'b1;
      step(1, 0, 4'b0000, 4'b0000, 2'd2, 1, 0, "arst.restart");
      step(1, 0, 4'b0100, 4'b0000, 2'd2, 1, 0, "arst.rework");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
